ms_result_display: RTL and testbench
====================================

Name: ms_result_display

Overview:
Downstream consumer of the reaction-timer millisecond counter. On the counter's one-cycle done pulse it captures the 10-bit ms result and converts it to 4 BCD digits using an iterative double-dabble (one bit per clock). It then drives the 4-digit, active-low, multiplexed 7-segment display, with leading-zero blanking. The last result is held on the display until the next done pulse.

Parameters:
REFRESH_COUNT, 100000, clk cycles per digit slot (1 ms at 100 MHz); legal range >= 2
BLANK_LZ, 1, 1 = blank leading zeros; 0 = show all four digits

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
done  in  1  one-cycle pulse from the ms counter; result valid in the same cycle
ms  in  10  millisecond result, 0..1023
busy  out  1  high while a conversion is in progress (CONV or LOAD)
result_valid  out  1  one-cycle pulse when new digits are committed to the display
an  out  4  digit anodes, active-low, one-hot-low; an[0] = rightmost digit
seg  out  8  segments, active-low; seg[6:0] = {g,f,e,d,c,b,a}; seg[7] = dp, held 1 (off)

Behaviour:
- Reset values:
  - State IDLE; shift register and all digit registers 0; iteration count 0.
  - busy = 0, result_valid = 0.
  - Scan index 0, refresh counter 0; an = 4'b1110, seg = 8'b1100_0000 (shows "0").
- FSM states:
  - IDLE: busy = 0. If done = 1, load ms into the 10-bit shift register, clear the 16-bit BCD working register, set iteration count to 0, go to CONV.
  - CONV: busy = 1. Each cycle:
    - Add 3 to every working nibble >= 5.
    - Shift {bcd, bin} left by 1.
    - Increment the iteration count.
    - After the 10th shift (count == 9 on entry), go to LOAD.
  - LOAD: busy = 1. Copy the working register into the display digit registers d3..d0, go to IDLE.
- result_valid: registered; high for exactly one cycle, coincident with the first cycle the new digits are visible.
- Latency: done high in cycle 0 -> CONV in cycles 1–10 -> LOAD in cycle 11 -> new digits and result_valid in cycle 12.
- Width rules:
  - 10-bit input, max 1023, so d3 is only ever 0 or 1.
  - No saturation; the value is shown exactly as received.
- Boundary conditions:
  - done while in CONV or LOAD: abort, reload the new ms value, restart CONV from iteration 0. Display digits are unchanged until the restarted conversion completes.
  - done in the same cycle as LOAD: LOAD completes (old result committed, result_valid still pulses), then the state goes directly to CONV with the new ms value.
  - rst mid-conversion: immediate return to reset values; the partial result is discarded.
- Display scan:
  - The refresh counter counts 0..REFRESH_COUNT-1, then wraps and increments the 2-bit scan index (wraps 3 -> 0).
  - an and seg are registered and change together on the index increment.
  - The display runs continuously, independent of the FSM.
- Blanking (BLANK_LZ = 1):
  - Digit k is blanked (seg = 8'hFF, its an stays driven) if it and all higher digits are 0, for k = 3..1.
  - d0 is never blanked.
- Decoder: codes 0–9 use standard patterns; codes 10–15 must never occur and decode to all-off.

Decomposition:
- Package ms_disp_pkg:
  - state enum {IDLE, CONV, LOAD}
  - N_DIGITS = 4, MS_WIDTH = 10, ITER_LAST = 9
  - SEG_BLANK = 8'hFF
  - 10-entry segment pattern constant array
- Sub-module bcd_to_sseg: combinational 4-bit code + blank input -> 8-bit seg. Instantiated once, after the scan mux.
- Top contains the FSM, double-dabble datapath, refresh counter and output registers.

Test Plan:
- ms = 1023, done pulse -> busy high cycles 1–11, result_valid in cycle 12, digits 1,0,2,3. With REFRESH_COUNT = 4, each scan slot shows the correct an/seg: "3" = 8'b1011_0000, "2" = 8'b1010_0100, "0" = 8'b1100_0000, "1" = 8'b1111_1001.
- ms = 7 -> d3..d1 blanked (seg = 8'hFF in those slots), d0 = 8'b1111_1000. With BLANK_LZ = 0, all slots show "0007".
- ms = 0 -> only d0 is lit, showing "0"; ms = 100 -> "100" with d3 blank; ms = 509 -> d1 shows "0" unblanked.
- Display 250; then done with ms = 5 at cycle 4 of CONV for 999 -> a single result_valid ~12 cycles after the second done; display goes "250" -> "5"; 999 never appears.
- Assert rst during cycle 6 of CONV for 456 -> all outputs return to reset values that cycle; no result_valid; display shows "0".
- Scan check with REFRESH_COUNT = 4 -> an sequence 1110, 1101, 1011, 0111 repeating, each held 4 cycles; never two anodes low at once.

Source files
------------

// File: rtl/ms_disp_pkg.sv
// Shared types and constants for the millisecond result display.
// Contents: FSM state enum, digit/width constants, the active-low
// seven-segment pattern table and a digit-index to anode helper.
package ms_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_e;

  localparam int N_DIGITS  = 4;
  localparam int MS_WIDTH  = 10;
  localparam int ITER_LAST = 9;
  localparam int BCD_W     = 4 * N_DIGITS;
  localparam int IDX_W     = $clog2(N_DIGITS);

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is always off.
  localparam logic [7:0] SEG_PATTERN [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  // One-hot-low anode vector for a digit slot; slot 0 is the rightmost digit.
  function automatic logic [N_DIGITS-1:0] anode_for(input logic [IDX_W-1:0] idx);
    logic [N_DIGITS-1:0] a;
    a      = '1;
    a[idx] = 1'b0;
    return a;
  endfunction

endpackage

// File: rtl/ms_result_display_if.sv
// Bus between the ms counter / display pins and ms_result_display.
//   done, ms            : result handshake from the counter (master drives)
//   busy, result_valid  : conversion status (display drives)
//   an, seg             : active-low multiplexed 7-segment pins (display drives)
interface ms_result_display_if;
  import ms_disp_pkg::*;

  logic                done;
  logic [MS_WIDTH-1:0] ms;
  logic                busy;
  logic                result_valid;
  logic [N_DIGITS-1:0] an;
  logic [7:0]          seg;

  modport master (output done, ms, input busy, result_valid, an, seg);
  modport slave  (input done, ms, output busy, result_valid, an, seg);
endinterface

// File: rtl/ms_result_display_bcd_to_sseg.sv
// Combinational BCD digit to active-low seven-segment decoder.
//   code_i  : 4-bit digit code; 10..15 are illegal and decode to all-off
//   blank_i : force all segments off (leading-zero blanking)
//   seg_o   : {dp,g,f,e,d,c,b,a}, active-low
module bcd_to_sseg
  import ms_disp_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i && (code_i < 4'd10)) seg_o = SEG_PATTERN[code_i];
  end

endmodule

// File: rtl/ms_result_display.sv
// Captures a 10-bit millisecond result on the counter's done pulse, converts
// it to four BCD digits by iterative double-dabble (one bit per clock) and
// drives a 4-digit multiplexed active-low 7-segment display with optional
// leading-zero blanking. The last result stays on the display until the next
// conversion completes.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of ms_result_display_if (done/ms in; busy,
//              result_valid, an, seg out)
module ms_result_display
  import ms_disp_pkg::*;
#(
  parameter int REFRESH_COUNT = 100000,  // clk cycles per digit slot, >= 2
  parameter bit BLANK_LZ      = 1'b1     // 1 = blank leading zeros
) (
  input  logic               clk,
  input  logic               rst,
  ms_result_display_if.slave bus
);

  localparam int               CNT_W    = $clog2(REFRESH_COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_COUNT - 1);

  state_e                         state_q, state_d;
  logic [MS_WIDTH-1:0]            bin_q, bin_d;
  logic [BCD_W-1:0]               bcd_q, bcd_d, bcd_adj;
  logic [3:0]                     iter_q, iter_d;
  logic [N_DIGITS-1:0][3:0]       dig_q, dig_d;
  logic                           valid_q, valid_d;

  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [N_DIGITS-1:0]            an_q, an_d;
  logic [7:0]                     seg_q, seg_d;
  logic [N_DIGITS-1:0]            blank;

  // Double-dabble correction: add 3 to every nibble >= 5 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    dig_d   = dig_q;
    valid_d = 1'b0;

    case (state_q)
      CONV: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        iter_d         = iter_q + 4'd1;
        if (iter_q == 4'(ITER_LAST)) state_d = LOAD;
      end
      LOAD: begin
        dig_d   = bcd_q;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: ;
    endcase

    // A new result in any state (re)starts the conversion. In LOAD the commit
    // above still happens, so the old result is shown and flagged first.
    if (bus.done) begin
      state_d = CONV;
      bin_d   = bus.ms;
      bcd_d   = '0;
      iter_d  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // The digit registers are reset too, so the display shows "0" after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      dig_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      iter_q  <= iter_d;
      dig_q   <= dig_d;
      valid_q <= valid_d;
    end
  end

  // Refresh counter and scan index; runs regardless of the FSM.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = idx_q + 1'b1;
    end
  end

  // A digit is blank when it and every higher digit are zero; d0 never is.
  always_comb begin
    logic hi_zero;
    blank   = '0;
    hi_zero = 1'b1;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      hi_zero  = hi_zero & (dig_d[k] == 4'd0);
      blank[k] = BLANK_LZ & hi_zero;
    end
  end

  // Decode from next-state index and digits so an and seg switch together and
  // a committed result is visible in the same cycle as result_valid.
  bcd_to_sseg u_dec (
    .code_i  (dig_d[idx_d]),
    .blank_i (blank[idx_d]),
    .seg_o   (seg_d)
  );

  assign an_d = anode_for(idx_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      an_q  <= anode_for('0);
      seg_q <= SEG_PATTERN[0];
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign bus.busy         = (state_q != IDLE);
  assign bus.result_valid = valid_q;
  assign bus.an           = an_q;
  assign bus.seg          = seg_q;

endmodule

// File: tb/tb_ms_result_display.sv
// Directed bench for ms_result_display: two instances (leading-zero blanking
// on and off) with REFRESH_COUNT = 4 share the same stimulus.
module tb_ms_result_display;
  import ms_disp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ms_result_display_if bus_a ();
  ms_result_display_if bus_b ();

  ms_result_display #(.REFRESH_COUNT(4), .BLANK_LZ(1'b1)) dut_a (
    .clk (clk), .rst (rst), .bus (bus_a)
  );
  ms_result_display #(.REFRESH_COUNT(4), .BLANK_LZ(1'b0)) dut_b (
    .clk (clk), .rst (rst), .bus (bus_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expected seg per slot, packed as {slot3, slot2, slot1, slot0}.
  localparam logic [3:0][7:0] T1023   = {8'hF9, 8'hC0, 8'hA4, 8'hB0};
  localparam logic [3:0][7:0] T7_A    = {8'hFF, 8'hFF, 8'hFF, 8'hF8};
  localparam logic [3:0][7:0] T7_B    = {8'hC0, 8'hC0, 8'hC0, 8'hF8};
  localparam logic [3:0][7:0] T0_A    = {8'hFF, 8'hFF, 8'hFF, 8'hC0};
  localparam logic [3:0][7:0] T0_B    = {8'hC0, 8'hC0, 8'hC0, 8'hC0};
  localparam logic [3:0][7:0] T100_A  = {8'hFF, 8'hF9, 8'hC0, 8'hC0};
  localparam logic [3:0][7:0] T100_B  = {8'hC0, 8'hF9, 8'hC0, 8'hC0};
  localparam logic [3:0][7:0] T509_A  = {8'hFF, 8'h92, 8'hC0, 8'h90};
  localparam logic [3:0][7:0] T509_B  = {8'hC0, 8'h92, 8'hC0, 8'h90};
  localparam logic [3:0][7:0] T250_A  = {8'hFF, 8'hA4, 8'h92, 8'hC0};
  localparam logic [3:0][7:0] T250_B  = {8'hC0, 8'hA4, 8'h92, 8'hC0};
  localparam logic [3:0][7:0] T5_A    = {8'hFF, 8'hFF, 8'hFF, 8'h92};
  localparam logic [3:0][7:0] T5_B    = {8'hC0, 8'hC0, 8'hC0, 8'h92};

  task automatic drive(input logic d, input logic [9:0] v);
    bus_a.done = d;
    bus_a.ms   = v;
    bus_b.done = d;
    bus_b.ms   = v;
  endtask

  function automatic int slot_of(input logic [3:0] an);
    case (an)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // Watch 16 cycles (4 full scans) and compare each slot on both instances.
  task automatic check_scan(input string tag, input logic [3:0][7:0] exp_a,
                            input logic [3:0][7:0] exp_b);
    logic [3:0] seen;
    int sa, sb;
    seen = '0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      sa = slot_of(bus_a.an);
      sb = slot_of(bus_b.an);
      n_checks++;
      if (sa < 0) begin
        n_fail++;
        $display("FAIL %s an_a: got %b, want one-hot-low", tag, bus_a.an);
      end else begin
        seen[sa] = 1'b1;
        n_checks++;
        if (bus_a.seg !== exp_a[sa]) begin
          n_fail++;
          $display("FAIL %s seg_a slot%0d: got %h, want %h", tag, sa, bus_a.seg, exp_a[sa]);
        end
      end
      n_checks++;
      if (sb < 0) begin
        n_fail++;
        $display("FAIL %s an_b: got %b, want one-hot-low", tag, bus_b.an);
      end else begin
        n_checks++;
        if (bus_b.seg !== exp_b[sb]) begin
          n_fail++;
          $display("FAIL %s seg_b slot%0d: got %h, want %h", tag, sb, bus_b.seg, exp_b[sb]);
        end
      end
    end
    n_checks++;
    if (seen !== 4'hF) begin
      n_fail++;
      $display("FAIL %s slots_seen: got %b, want 1111", tag, seen);
    end
  endtask

  // One done pulse, then busy/result_valid timing: busy cycles 1-11, valid 12.
  task automatic run_conversion(input string tag, input logic [9:0] v);
    @(negedge clk);
    drive(1'b1, v);
    @(negedge clk);
    drive(1'b0, '0);
    for (int c = 1; c <= 13; c++) begin
      n_checks++;
      if (bus_a.busy !== (c <= 11)) begin
        n_fail++;
        $display("FAIL %s busy c%0d: got %b, want %b", tag, c, bus_a.busy, (c <= 11));
      end
      n_checks++;
      if (bus_a.result_valid !== (c == 12)) begin
        n_fail++;
        $display("FAIL %s result_valid c%0d: got %b, want %b", tag, c,
                 bus_a.result_valid, (c == 12));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp_an;
    rst = 1'b1;
    drive(1'b0, '0);
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus_a.busy !== 1'b0 || bus_a.result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: got busy=%b valid=%b, want 0 0", bus_a.busy, bus_a.result_valid);
    end
    n_checks++;
    if (bus_a.an !== 4'b1110 || bus_a.seg !== 8'hC0) begin
      n_fail++;
      $display("FAIL reset_display: got an=%b seg=%h, want 1110 c0", bus_a.an, bus_a.seg);
    end
    rst = 1'b0;
    // Each slot held 4 cycles, slots 0,1,2,3,0,... from reset release.
    for (int j = 0; j < 20; j++) begin
      #1;
      exp_an = 4'b1111;
      exp_an[(j / 4) % 4] = 1'b0;
      n_checks++;
      if (bus_a.an !== exp_an) begin
        n_fail++;
        $display("FAIL scan_seq j%0d: got %b, want %b", j, bus_a.an, exp_an);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_values();
    run_conversion("ms1023", 10'd1023);
    check_scan("ms1023", T1023, T1023);
    run_conversion("ms7", 10'd7);
    check_scan("ms7", T7_A, T7_B);
    run_conversion("ms0", 10'd0);
    check_scan("ms0", T0_A, T0_B);
    run_conversion("ms100", 10'd100);
    check_scan("ms100", T100_A, T100_B);
    run_conversion("ms509", 10'd509);
    check_scan("ms509", T509_A, T509_B);
  endtask

  // 999 is aborted at CONV cycle 4 by a done carrying 5; result at cycle 16.
  task automatic test_abort();
    int sa;
    logic [3:0][7:0] exp;
    run_conversion("ms250", 10'd250);
    check_scan("ms250", T250_A, T250_B);
    @(negedge clk);
    drive(1'b1, 10'd999);
    @(negedge clk);
    drive(1'b0, '0);
    for (int c = 1; c <= 24; c++) begin
      n_checks++;
      if (bus_a.busy !== (c <= 15)) begin
        n_fail++;
        $display("FAIL abort busy c%0d: got %b, want %b", c, bus_a.busy, (c <= 15));
      end
      n_checks++;
      if (bus_a.result_valid !== (c == 16)) begin
        n_fail++;
        $display("FAIL abort result_valid c%0d: got %b, want %b", c,
                 bus_a.result_valid, (c == 16));
      end
      sa  = slot_of(bus_a.an);
      exp = (c >= 16) ? T5_A : T250_A;
      n_checks++;
      if (sa < 0 || bus_a.seg !== exp[(sa < 0) ? 0 : sa]) begin
        n_fail++;
        $display("FAIL abort seg c%0d: got an=%b seg=%h, want slot pattern of %s",
                 c, bus_a.an, bus_a.seg, (c >= 16) ? "5" : "250");
      end
      if (c == 4) drive(1'b1, 10'd5);
      else        drive(1'b0, '0);
      @(negedge clk);
    end
    check_scan("abort_final", T5_A, T5_B);
  endtask

  // done during LOAD: 1023 commits at cycle 12, then 7 converts, valid at 23.
  task automatic test_load_overlap();
    int sa;
    logic [3:0][7:0] exp;
    @(negedge clk);
    drive(1'b1, 10'd1023);
    @(negedge clk);
    drive(1'b0, '0);
    for (int c = 1; c <= 26; c++) begin
      n_checks++;
      if (bus_a.busy !== (c <= 22)) begin
        n_fail++;
        $display("FAIL overlap busy c%0d: got %b, want %b", c, bus_a.busy, (c <= 22));
      end
      n_checks++;
      if (bus_a.result_valid !== (c == 12 || c == 23)) begin
        n_fail++;
        $display("FAIL overlap result_valid c%0d: got %b, want %b", c,
                 bus_a.result_valid, (c == 12 || c == 23));
      end
      sa  = slot_of(bus_a.an);
      exp = (c >= 23) ? T7_A : ((c >= 12) ? T1023 : T5_A);
      n_checks++;
      if (sa < 0 || bus_a.seg !== exp[(sa < 0) ? 0 : sa]) begin
        n_fail++;
        $display("FAIL overlap seg c%0d: got an=%b seg=%h", c, bus_a.an, bus_a.seg);
      end
      if (c == 11) drive(1'b1, 10'd7);
      else         drive(1'b0, '0);
      @(negedge clk);
    end
  endtask

  // Reset in CONV cycle 6 of 456: immediate reset values, no result ever.
  task automatic test_reset_mid();
    @(negedge clk);
    drive(1'b1, 10'd456);
    @(negedge clk);
    drive(1'b0, '0);
    repeat (5) @(negedge clk);
    n_checks++;
    if (bus_a.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst pre_busy: got %b, want 1", bus_a.busy);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus_a.busy !== 1'b0 || bus_a.result_valid !== 1'b0 ||
        bus_a.an !== 4'b1110 || bus_a.seg !== 8'hC0 || bus_b.seg !== 8'hC0) begin
      n_fail++;
      $display("FAIL midrst outputs: got busy=%b valid=%b an=%b seg_a=%h seg_b=%h, want 0 0 1110 c0 c0",
               bus_a.busy, bus_a.result_valid, bus_a.an, bus_a.seg, bus_b.seg);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      n_checks++;
      if (bus_a.busy !== 1'b0 || bus_a.result_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst after c%0d: got busy=%b valid=%b, want 0 0",
                 c, bus_a.busy, bus_a.result_valid);
      end
      @(negedge clk);
    end
    check_scan("midrst_display", T0_A, T0_B);
  endtask

  initial begin
    test_reset();
    test_values();
    test_abort();
    test_load_overlap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
